alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle instruction sequencer that acts as the initiator for the 16-bit two-operand ALU. It accepts one 16-bit instruction per handshake and decodes it. It reads operands from an internal 8x16 register file, shifts the B operand, and drives the ALU operand and op lines. It then captures the ALU result and zero flag, writes back to the register file, and updates the N/V/Z status.

## Interface
- No parameters. Data width is fixed at 16 and the register file at 8 entries.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Clears all state, including the register file.
- in_valid  in  1  instruction present on instr.
- in_ready  out  1  high only in WAIT.
- instr  in  16  instruction. Fields: opc[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- alu_a  out  16  ALU A operand; equals the A register.
- alu_b  out  16  ALU B operand; equals the shifted-B register.
- alu_op  out  2  ALU function: 00 add, 01 sub, 10 and, 11 not-B.
- alu_out  in  16  ALU result; combinational from alu_a/alu_b/alu_op.
- alu_z  in  1  ALU zero flag for alu_out.
- done  out  1  one-cycle pulse in DONE.
- illegal  out  1  high with done when the instruction was undecodable.
- status  out  3  {N,V,Z}, registered.
- rd_sel  in  3  debug read select.
- rd_data  out  16  combinational register-file read: R[rd_sel].

## Operation
- Decode:
  - opc=110, op=10: MOV Rn,#imm8. Writes sign-extended imm8 to R[Rn].
  - opc=110, op=00: MOV Rd,Rm{sh}. Writes 0 + shift(R[Rm]) through the ALU, with alu_op=00. Status unchanged.
  - opc=101: ALU op. op 00 ADD Rd=Rn+sh(Rm); 01 CMP Rn−sh(Rm), no writeback; 10 AND Rd=Rn&sh(Rm); 11 MVN Rd=~sh(Rm).
  - All other opc/op combinations are illegal.
- Shift codes:
  - 00: none.
  - 01: LSL1, shifting a 0 into bit 0.
  - 10: LSR1, shifting a 0 into bit 15.
  - 11: ASR1, replicating bit 15.
- States, one cycle each:
  - WAIT: in_ready=1. When in_valid=1, latch instr and go to DECODE. Otherwise stay.
  - DECODE: MOV imm → WRITE; MOV shift → GETB; ALU ops → GETA; illegal → DONE.
  - GETA: A ← R[Rn]. MVN loads A as well; the ALU ignores it. → GETB.
  - GETB: B ← shift(R[Rm]). A ← 0 for MOV shift. → EXEC.
  - EXEC: alu_a/alu_b/alu_op are presented. C ← alu_out. For ADD/CMP/AND/MVN, status ← {alu_out[15], V, alu_z}. CMP → DONE; all others → WRITE.
  - WRITE: R[dest] ← C, or ← sext(imm8) for MOV imm. dest is Rn for MOV imm and Rd otherwise. → DONE.
  - DONE: done=1, illegal as decoded. → WAIT.
- Overflow flag V:
  - ADD: a[15]==b[15] && out[15]!=a[15].
  - CMP: a[15]!=b[15] && out[15]!=a[15].
  - AND and MVN: V=0.
- Arithmetic is modulo 2^16 and carry is discarded.
- Register write happens only in WRITE, to exactly one register.
- rd_data reflects a write from the cycle after the WRITE edge.

## Timing
- Reset values:
  - State WAIT, so in_ready=1.
  - done=0, illegal=0, status=000.
  - alu_a=0, alu_b=0, alu_op=00.
  - All registers R0–R7 and the A, B and C registers are 0.
- Latency, measured in edges from the acceptance edge to the edge entering DONE:
  - MOV imm: 2.
  - MOV shift: 4.
  - ADD/AND/MVN: 5.
  - CMP: 4.
  - Illegal: 1.
- done is high for exactly the one cycle after entering DONE. in_ready returns high on the following edge. Back-to-back instructions are therefore separated by at least one WAIT cycle.
- in_valid and instr are ignored outside WAIT. instr is sampled only on the acceptance edge.
- alu_op is registered at DECODE and stable from GETA through EXEC. alu_a and alu_b are stable during EXEC.
- Reset asserted in any state takes effect on that edge: return to WAIT and clear all registers. No pending write commits, done does not pulse, and status clears.
- Rn=Rd=Rm aliasing is legal. Operands are read before writeback, so ADD R1,R1,R1 doubles R1.

## Test plan
- Reset, then MOV R0,#5 and MOV R1,#−2. Required: rd_data for R0=0x0005 and R1=0xFFFE; done pulses 2 edges after each accept; status stays 000.
- With R0=5 and R1=3: ADD R2,R0,R1{LSL1}. Required: R2=0x000B, status=000, done 5 edges after accept. With R0=5 and R1=5: CMP R0,R1. Required: status=001, no register changes, done at 4 edges.
- With R0=0x7FFF and R1=1: ADD R3,R0,R1. Required: R3=0x8000, status=110. With R0=0x8000 and R1=1: CMP R0,R1. Required: status=010.
- With R4=0x8001: MOV R5,R4{ASR1}. Required: R5=0xC000, status unchanged. With R4=0x8001: MVN R6,R4{LSR1}. Required: R6=0xBFFF, status=100.
- Instruction 0xE000. Required: done and illegal high together 1 edge after accept; no register or status change. Then reset asserted during EXEC of an ADD. Required: next cycle in WAIT, all R=0, status=000, no done pulse.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer that drives an external 16-bit ALU.
// It has an 8x16 register file with writeback and registered N/V/Z status.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    output logic        done,
    output logic        illegal,
    output logic [2:0]  status,
    input  logic [2:0]  rd_sel,
    output logic [15:0] rd_data
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] c_reg;
    logic [1:0]  op_reg;
    logic [15:0] regs [8];

    logic [2:0]  opc;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] imm_sext;
    logic        is_mov_imm;
    logic        is_mov_sh;
    logic        is_alu;
    logic        is_cmp;
    logic        v_flag;

    assign opc        = ir[15:13];
    assign op         = ir[12:11];
    assign rn         = ir[10:8];
    assign rd         = ir[7:5];
    assign sh         = ir[4:3];
    assign rm         = ir[2:0];
    assign imm_sext   = {{8{ir[7]}}, ir[7:0]};
    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_sh  = (opc == 3'b110) && (op == 2'b00);
    assign is_alu     = (opc == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign alu_a   = a_reg;
    assign alu_b   = b_reg;
    assign alu_op  = op_reg;
    assign rd_data = regs[rd_sel];

    function automatic logic [15:0] shift_b(input logic [15:0] v, input logic [1:0] code);
        case (code)
            2'b01:   shift_b = {v[14:0], 1'b0};
            2'b10:   shift_b = {1'b0, v[15:1]};
            2'b11:   shift_b = {v[15], v[15:1]};
            default: shift_b = v;
        endcase
    endfunction

    // Signed overflow of the current ALU operation; only add and sub can overflow.
    always_comb begin
        v_flag = 1'b0;
        case (op_reg)
            2'b00:   v_flag = (a_reg[15] == b_reg[15]) && (alu_out[15] != a_reg[15]);
            2'b01:   v_flag = (a_reg[15] != b_reg[15]) && (alu_out[15] != a_reg[15]);
            default: v_flag = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_WAIT;
            in_ready <= 1'b1;
            done     <= 1'b0;
            illegal  <= 1'b0;
            status   <= 3'b000;
            ir       <= 16'h0000;
            a_reg    <= 16'h0000;
            b_reg    <= 16'h0000;
            c_reg    <= 16'h0000;
            op_reg   <= 2'b00;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (in_valid) begin
                        ir       <= instr;
                        in_ready <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // MOV-with-shift goes through the ALU as 0 + shifted operand.
                    op_reg <= is_alu ? op : 2'b00;
                    if (is_mov_imm) begin
                        state <= S_WRITE;
                    end else if (is_mov_sh) begin
                        state <= S_GETB;
                    end else if (is_alu) begin
                        state <= S_GETA;
                    end else begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_GETA: begin
                    a_reg <= regs[rn];
                    state <= S_GETB;
                end
                S_GETB: begin
                    b_reg <= shift_b(regs[rm], sh);
                    if (is_mov_sh) begin
                        a_reg <= 16'h0000;
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c_reg <= alu_out;
                    if (is_alu) begin
                        status <= {alu_out[15], v_flag, alu_z};
                    end
                    if (is_cmp) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (is_mov_imm) begin
                        regs[rn] <= imm_sext;
                    end else begin
                        regs[rd] <= c_reg;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done     <= 1'b0;
                    illegal  <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= S_WAIT;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU, a register/status
// model and a scoreboard of expected completions.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        done;
    logic        illegal;
    logic [2:0]  status;
    logic [2:0]  rd_sel;
    logic [15:0] rd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         lat;
        logic       ill;
        logic [2:0] st;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mr [8];
    logic [2:0]  mst;

    alu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_z    (alu_z),
        .done     (done),
        .illegal  (illegal),
        .status   (status),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the external ALU.
    always_comb begin
        alu_out = 16'h0000;
        case (alu_op)
            2'b00: alu_out = alu_a + alu_b;
            2'b01: alu_out = alu_a - alu_b;
            2'b10: alu_out = alu_a & alu_b;
            2'b11: alu_out = ~alu_b;
        endcase
        alu_z = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_imm(input logic [2:0] rn, input logic [7:0] imm);
        enc_imm = {3'b110, 2'b10, rn, imm};
    endfunction

    function automatic logic [15:0] enc_movs(input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm);
        enc_movs = {3'b110, 2'b00, 3'b000, rd, sh, rm};
    endfunction

    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] rn,
                                            input logic [2:0] rd, input logic [1:0] sh,
                                            input logic [2:0] rm);
        enc_alu = {3'b101, op, rn, rd, sh, rm};
    endfunction

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b00:   shf = v;
            2'b01:   shf = v << 1;
            2'b10:   shf = v >> 1;
            default: shf = $unsigned($signed(v) >>> 1);
        endcase
    endfunction

    // Predicts the outcome of one instruction, updates the model and queues the expectation.
    task automatic predict(input logic [15:0] ins);
        exp_t        e;
        logic [15:0] a, b, res;
        logic        v;
        e.ill = 1'b0;
        if (ins[15:13] == 3'b110 && ins[12:11] == 2'b10) begin
            mr[ins[10:8]] = {{8{ins[7]}}, ins[7:0]};
            e.lat = 2;
        end else if (ins[15:13] == 3'b110 && ins[12:11] == 2'b00) begin
            mr[ins[7:5]] = shf(mr[ins[2:0]], ins[4:3]);
            e.lat = 4;
        end else if (ins[15:13] == 3'b101) begin
            a = mr[ins[10:8]];
            b = shf(mr[ins[2:0]], ins[4:3]);
            v = 1'b0;
            case (ins[12:11])
                2'b00: begin res = a + b; v = (a[15] == b[15]) && (res[15] != a[15]); end
                2'b01: begin res = a - b; v = (a[15] != b[15]) && (res[15] != a[15]); end
                2'b10: res = a & b;
                default: res = ~b;
            endcase
            mst = {res[15], v, res == 16'h0000};
            if (ins[12:11] == 2'b01) begin
                e.lat = 4;
            end else begin
                mr[ins[7:5]] = res;
                e.lat = 5;
            end
        end else begin
            e.lat = 1;
            e.ill = 1'b1;
        end
        e.st = mst;
        sb.push_back(e);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            check($sformatf("%s R%0d", tag, i), {16'h0, rd_data}, {16'h0, mr[i]});
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] ins, input string tag);
        exp_t e;
        int   edges;
        predict(ins);
        @(negedge clk);
        check({tag, " in_ready"}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1;
        instr = 16'($urandom);
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(edges), 32'(e.lat));
        check({tag, " illegal"}, {31'h0, illegal}, {31'h0, e.ill});
        check({tag, " status"}, {29'h0, status}, {29'h0, e.st});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'h0, done}, 32'h0);
        check({tag, " ready_back"}, {31'h0, in_ready}, 32'h1);
        check_regs(tag);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        instr    = 16'h0000;
        rd_sel   = 3'd0;
        mst      = 3'b000;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset in_ready", {31'h0, in_ready}, 32'h1);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset illegal", {31'h0, illegal}, 32'h0);
        check("reset status", {29'h0, status}, 32'h0);
        check("reset alu_a", {16'h0, alu_a}, 32'h0);
        check("reset alu_b", {16'h0, alu_b}, 32'h0);
        check("reset alu_op", {30'h0, alu_op}, 32'h0);
        check_regs("reset");

        apply_stimulus(enc_imm(3'd0, 8'h05), "mov r0 5");
        apply_stimulus(enc_imm(3'd1, 8'hFE), "mov r1 -2");
        apply_stimulus(enc_imm(3'd1, 8'h03), "mov r1 3");
        apply_stimulus(enc_alu(2'b00, 3'd0, 3'd2, 2'b01, 3'd1), "add r2 lsl");
        apply_stimulus(enc_imm(3'd1, 8'h05), "mov r1 5");
        apply_stimulus(enc_alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1), "cmp eq");
        apply_stimulus(enc_imm(3'd0, 8'hFF), "mov r0 -1");
        apply_stimulus(enc_movs(3'd0, 2'b10, 3'd0), "mov r0 lsr");
        apply_stimulus(enc_imm(3'd1, 8'h01), "mov r1 1");
        apply_stimulus(enc_alu(2'b00, 3'd0, 3'd3, 2'b00, 3'd1), "add ovf");
        apply_stimulus(enc_movs(3'd0, 2'b00, 3'd3), "mov r0 r3");
        apply_stimulus(enc_alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1), "cmp ovf");
        apply_stimulus(enc_alu(2'b00, 3'd0, 3'd4, 2'b00, 3'd1), "add r4");
        apply_stimulus(enc_alu(2'b01, 3'd1, 3'd0, 2'b00, 3'd1), "cmp r1 r1");
        apply_stimulus(enc_movs(3'd5, 2'b11, 3'd4), "mov asr");
        apply_stimulus(enc_alu(2'b11, 3'd0, 3'd6, 2'b10, 3'd4), "mvn lsr");
        apply_stimulus(enc_alu(2'b10, 3'd5, 3'd7, 2'b00, 3'd6), "and r7");
        apply_stimulus(enc_alu(2'b00, 3'd1, 3'd1, 2'b00, 3'd1), "add alias");
        apply_stimulus(16'hE000, "illegal");

        // Reset while an ADD sits in EXEC: nothing may commit or pulse.
        @(negedge clk);
        in_valid = 1'b1;
        instr    = enc_alu(2'b00, 3'd4, 3'd2, 2'b00, 3'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("exec alu_op", {30'h0, alu_op}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mst = 3'b000;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        check("rst in_ready", {31'h0, in_ready}, 32'h1);
        check("rst status", {29'h0, status}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check_regs("rst");
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst no done", {31'h0, done}, 32'h0);
        end
        apply_stimulus(enc_imm(3'd2, 8'h7F), "post rst mov");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
